// File: rtl/ariane_pkg.sv
// Shared issue-path types: functional-unit encoding, the scoreboard entry
// and a helper that classifies LSU-bound instructions.
package ariane_pkg;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR,
        FPU,
        FPU_VEC,
        CVXIF,
        ACCEL
    } fu_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  trans_id;
        fu_t         fu;
        logic [7:0]  op;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [63:0] result;
        logic        valid;
        logic        use_imm;
    } scoreboard_entry_t;

    function automatic logic is_lsu_op(input fu_t fu);
        return (fu == LOAD) || (fu == STORE);
    endfunction

endpackage

// File: rtl/lsu_issue_throttle.sv
// Issue-path throttle for memory ops: enforces a minimum gap between LSU
// handshakes, holds them while the LSU is busy, and forces starved ops through.
module lsu_issue_throttle
    import ariane_pkg::*;
#(
    parameter int unsigned MIN_GAP  = 2,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              debug_req_i,
    input  scoreboard_entry_t issue_entry_i,
    input  logic              issue_entry_valid_i,
    input  logic              is_ctrl_flow_i,
    output logic              issue_instr_ack_o,
    output scoreboard_entry_t issue_entry_o,
    output logic              issue_entry_valid_o,
    output logic              is_ctrl_flow_o,
    input  logic              issue_instr_ack_i,
    input  logic              lsu_ready_i,
    output logic [STAT_W-1:0] throttle_cnt_o
);

    localparam int unsigned GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(MIN_GAP);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        COOLDOWN
    } state_e;

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [STAT_W-1:0]  throttle_cnt_q;

    logic mem_i;
    logic force_issue;
    logic block;
    logic mem_hs;

    // Handshake: an instruction moves when valid is high and the issue stage
    // acks in the same cycle; blocking drops both valid_o and ack_o together,
    // so ID never sees an ack for an instruction issue_stage did not receive.
    assign mem_i       = issue_entry_valid_i & is_lsu_op(issue_entry_i.fu);
    assign force_issue = (hold_cnt_q == HOLD_MAX);

    assign issue_entry_o  = issue_entry_i;
    assign is_ctrl_flow_o = is_ctrl_flow_i;
    assign throttle_cnt_o = throttle_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_hs && (MIN_GAP > 0)) begin
                    state_d   = COOLDOWN;
                    gap_cnt_d = GAP_INIT;
                end
            end
            COOLDOWN: begin
                // A handshake here can only be a forced one; restart the gap.
                if (mem_hs) begin
                    gap_cnt_d = GAP_INIT;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                gap_cnt_d = '0;
            end
        endcase
        if (flush_i || debug_req_i) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
        end
    end

    always_comb begin
        block = mem_i & ~debug_req_i &
                (~lsu_ready_i | ((state_q == COOLDOWN) & ~force_issue));
        issue_entry_valid_o = issue_entry_valid_i & ~block;
        issue_instr_ack_o   = issue_instr_ack_i & ~block;
        mem_hs              = mem_i & issue_entry_valid_o & issue_instr_ack_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= '0;
        end else if (mem_hs || !mem_i || flush_i || debug_req_i) begin
            hold_cnt_q <= '0;
        end else if (block && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
    end

    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            throttle_cnt_q <= '0;
        end else if (block && (throttle_cnt_q != '1)) begin
            throttle_cnt_q <= throttle_cnt_q + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_lsu_issue_throttle.sv
// Directed bench for lsu_issue_throttle using three parameterisations that
// share one stimulus bus; each scenario resets and checks only its target.
module tb_lsu_issue_throttle;
    import ariane_pkg::*;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_COOL = 32'd1;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              dbg;
    scoreboard_entry_t entry;
    logic              entry_valid;
    logic              ctrl_flow;
    logic              ack_in;
    logic              lsu_ready;

    scoreboard_entry_t a_entry, b_entry, c_entry;
    logic              a_valid, b_valid, c_valid;
    logic              a_ack, b_ack, c_ack;
    logic              a_cf, b_cf, c_cf;
    logic [15:0]       a_thr;
    logic [2:0]        b_thr;
    logic [15:0]       c_thr;

    int checks;
    int failures;

    lsu_issue_throttle #(.MIN_GAP(2), .MAX_HOLD(8), .STAT_W(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_req_i(dbg),
        .issue_entry_i(entry), .issue_entry_valid_i(entry_valid),
        .is_ctrl_flow_i(ctrl_flow), .issue_instr_ack_o(a_ack),
        .issue_entry_o(a_entry), .issue_entry_valid_o(a_valid),
        .is_ctrl_flow_o(a_cf), .issue_instr_ack_i(ack_in),
        .lsu_ready_i(lsu_ready), .throttle_cnt_o(a_thr)
    );

    lsu_issue_throttle #(.MIN_GAP(20), .MAX_HOLD(4), .STAT_W(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_req_i(dbg),
        .issue_entry_i(entry), .issue_entry_valid_i(entry_valid),
        .is_ctrl_flow_i(ctrl_flow), .issue_instr_ack_o(b_ack),
        .issue_entry_o(b_entry), .issue_entry_valid_o(b_valid),
        .is_ctrl_flow_o(b_cf), .issue_instr_ack_i(ack_in),
        .lsu_ready_i(lsu_ready), .throttle_cnt_o(b_thr)
    );

    lsu_issue_throttle #(.MIN_GAP(5), .MAX_HOLD(8), .STAT_W(16)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_req_i(dbg),
        .issue_entry_i(entry), .issue_entry_valid_i(entry_valid),
        .is_ctrl_flow_i(ctrl_flow), .issue_instr_ack_o(c_ack),
        .issue_entry_o(c_entry), .issue_entry_valid_o(c_valid),
        .is_ctrl_flow_o(c_cf), .issue_instr_ack_i(ack_in),
        .lsu_ready_i(lsu_ready), .throttle_cnt_o(c_thr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        flush       = 1'b0;
        dbg         = 1'b0;
        entry       = '0;
        entry.fu    = NONE;
        entry_valid = 1'b0;
        ctrl_flow   = 1'b0;
        ack_in      = 1'b1;
        lsu_ready   = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_state_a", 32'(dut_a.state_q), ST_IDLE);
        check("rst_thr_a", 32'(a_thr), 32'd0);
        check("rst_hold_b", 32'(dut_b.hold_cnt_q), 32'd0);
        check("rst_gap_c", 32'(dut_c.gap_cnt_q), 32'd0);
        rst_n = 1'b1;
    endtask

    // One cycle: drive just after the edge, leave settle time before checks.
    task automatic cyc(input fu_t fu, input logic v, input logic rdy,
                       input logic fl, input logic dg);
        @(posedge clk);
        #1;
        entry       = '0;
        entry.fu    = fu;
        entry.pc    = 64'(32'h8000_0000 + $urandom_range(0, 255) * 4);
        entry_valid = v;
        lsu_ready   = rdy;
        flush       = fl;
        dbg         = dg;
        ctrl_flow   = (fu == CTRL_FLOW);
        #3;
    endtask

    initial begin
        logic [10:0] exp_v;
        checks   = 0;
        failures = 0;

        // Back-to-back loads with MIN_GAP=2: issues at t=0,3,6,9.
        do_reset();
        exp_v = 11'b010_0100_1001;
        for (int t = 0; t <= 10; t++) begin
            cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("gap2_valid_t%0d", t), 32'(a_valid), 32'(exp_v[t]));
            check($sformatf("gap2_ack_t%0d", t), 32'(a_ack), 32'(exp_v[t]));
            if (t == 0) check("gap2_pc_pass", a_entry.pc[31:0], entry.pc[31:0]);
        end
        check("gap2_thr_t10", 32'(a_thr), 32'd6);

        // Non-memory ops flow through cooldown, which keeps counting down.
        do_reset();
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("alu_load_t0", 32'(a_valid), 32'd1);
        cyc(ALU, 1'b1, 1'b1, 1'b0, 1'b0);
        check("alu_valid_t1", 32'(a_valid), 32'd1);
        check("alu_state_t1", 32'(dut_a.state_q), ST_COOL);
        cyc(CTRL_FLOW, 1'b1, 1'b1, 1'b0, 1'b0);
        check("alu_valid_t2", 32'(a_valid), 32'd1);
        check("alu_cf_t2", 32'(a_cf), 32'd1);
        cyc(ALU, 1'b1, 1'b1, 1'b0, 1'b0);
        check("alu_valid_t3", 32'(a_valid), 32'd1);
        check("alu_state_t3", 32'(dut_a.state_q), ST_IDLE);
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("alu_load_t4", 32'(a_valid), 32'd1);
        check("alu_thr_t4", 32'(a_thr), 32'd0);

        // Starvation guard: MIN_GAP=20, MAX_HOLD=4, store forced at t=5.
        do_reset();
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("force_load_t0", 32'(b_valid), 32'd1);
        for (int t = 1; t <= 4; t++) begin
            cyc(STORE, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("force_block_t%0d", t), 32'(b_valid), 32'd0);
        end
        cyc(STORE, 1'b1, 1'b1, 1'b0, 1'b0);
        check("force_valid_t5", 32'(b_valid), 32'd1);
        check("force_hold_t5", 32'(dut_b.hold_cnt_q), 32'd4);
        cyc(ALU, 1'b1, 1'b1, 1'b0, 1'b0);
        check("force_gap_t6", 32'(dut_b.gap_cnt_q), 32'd20);
        check("force_state_t6", 32'(dut_b.state_q), ST_COOL);
        check("force_hold_t6", 32'(dut_b.hold_cnt_q), 32'd0);

        // LSU not ready is never waived; STAT_W=3 counter saturates at 7.
        do_reset();
        for (int t = 0; t < 10; t++) begin
            cyc(LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("nrdy_valid_t%0d", t), 32'(b_valid), 32'd0);
        end
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("nrdy_issue_t10", 32'(b_valid), 32'd1);
        check("nrdy_hold_sat", 32'(dut_b.hold_cnt_q), 32'd4);
        check("nrdy_thr_sat", 32'(b_thr), 32'd7);

        // Flush during cooldown (MIN_GAP=5).
        do_reset();
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("flush_load_t0", 32'(c_valid), 32'd1);
        cyc(STORE, 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_block_t1", 32'(c_valid), 32'd0);
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("flush_issue_t2", 32'(c_valid), 32'd1);
        check("flush_state_t2", 32'(dut_c.state_q), ST_IDLE);
        check("flush_gap_t2", 32'(dut_c.gap_cnt_q), 32'd0);
        check("flush_hold_t2", 32'(dut_c.hold_cnt_q), 32'd0);
        check("flush_thr_t2", 32'(c_thr), 32'd1);

        // Debug bypass, then asynchronous reset mid-cooldown.
        do_reset();
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(STORE, 1'b1, 1'b1, 1'b0, 1'b1);
        check("dbg_valid_t1", 32'(c_valid), 32'd1);
        check("dbg_ack_t1", 32'(c_ack), 32'd1);
        cyc(ALU, 1'b1, 1'b1, 1'b0, 1'b0);
        check("dbg_state_t2", 32'(dut_c.state_q), ST_IDLE);
        check("dbg_gap_t2", 32'(dut_c.gap_cnt_q), 32'd0);
        cyc(LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("dbg_load_t3", 32'(c_valid), 32'd1);
        cyc(STORE, 1'b1, 1'b1, 1'b0, 1'b0);
        check("dbg_block_t4", 32'(c_valid), 32'd0);
        cyc(STORE, 1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_rst_state", 32'(dut_c.state_q), ST_COOL);
        check("pre_rst_thr", 32'(c_thr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(dut_c.state_q), ST_IDLE);
        check("async_rst_thr", 32'(c_thr), 32'd0);
        check("async_rst_valid", 32'(c_valid), 32'd1);
        #1;
        rst_n = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=%0d expected=%0d", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
